// File: rtl/uart_rx_io.sv
`timescale 1ns/1ps
// uart_rx_io: 8N1 UART receiver with a small receive FIFO, read by the Z80
// through IO port 9 (data) and IO port 11 (status).
//
// Bus handshake: a read access is the interval during which the decode
// (address match && IORQ && RD && !WR) is true; Data is driven combinationally
// for that whole interval and the access side effect (pop / flag clear) is
// taken exactly once, on the first clock edge that sees the decode true.
module uart_rx_io #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Address,
  inout  wire  [7:0] Data,
  input  logic       IORQ,
  input  logic       RD,
  input  logic       WR,
  input  logic       uart_rx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(BAUD_DIV / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LOAD = BAUD_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t              state, state_next;
  logic                rx_s1, rxs, rxs_d;
  logic [1:0]          flush_cnt;
  logic                rx_fall;
  logic [BAUD_W-1:0]   baud_cnt;
  logic                baud_done;
  logic [2:0]          bcnt;
  logic [7:0]          shreg;
  logic                load_half, load_full, shift_en, stop_eval;

  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                empty, full, push, pop;
  logic                ovr, ferr, ovr_set, ferr_set;

  logic                rd_data_dec, rd_stat_dec, rd_data_q, rd_stat_q;
  logic                rd_data_edge, rd_stat_edge;
  logic                data_oe;
  logic [7:0]          head, data_out;

  // Two-flop synchroniser plus edge history; flush_cnt keeps the reset value
  // of the sync flops from looking like a real 1->0 transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rxs       <= 1'b1;
      rxs_d     <= 1'b1;
      flush_cnt <= 2'd0;
    end else begin
      rx_s1 <= uart_rx;
      rxs   <= rx_s1;
      rxs_d <= rxs;
      if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
    end
  end

  assign rx_fall   = (flush_cnt == 2'd3) && rxs_d && !rxs;
  assign baud_done = (baud_cnt == '0);

  // Frame FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Frame FSM next state and datapath strobes.
  always_comb begin
    state_next = state;
    load_half  = 1'b0;
    load_full  = 1'b0;
    shift_en   = 1'b0;
    stop_eval  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_fall) begin
          state_next = START;
          load_half  = 1'b1;
        end
      end
      START: begin
        if (baud_done) begin
          if (!rxs) begin
            state_next = DATA;
            load_full  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (baud_done) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bcnt == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (baud_done) begin
          stop_eval  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Baud timer, bit counter and LSB-first shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bcnt     <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      if (load_half)       baud_cnt <= HALF_LOAD;
      else if (load_full)  baud_cnt <= FULL_LOAD;
      else if (!baud_done) baud_cnt <= baud_cnt - BAUD_W'(1);
      if (load_half)      bcnt <= 3'd0;
      else if (shift_en)  bcnt <= bcnt + 3'd1;
      if (shift_en) shreg <= {rxs, shreg[7:1]};
    end
  end

  assign rd_data_dec  = (Address == 8'd9)  && IORQ && RD && !WR;
  assign rd_stat_dec  = (Address == 8'd11) && IORQ && RD && !WR;
  assign rd_data_edge = rd_data_dec && !rd_data_q;
  assign rd_stat_edge = rd_stat_dec && !rd_stat_q;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign pop      = rd_data_edge && !empty;
  // A full FIFO being popped on the same clock still has room for the new byte.
  assign push     = stop_eval && rxs && (!full || pop);
  assign ovr_set  = stop_eval && rxs && full && !pop;
  assign ferr_set = stop_eval && !rxs;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, occupancy, sticky flags and registered read decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovr       <= 1'b0;
      ferr      <= 1'b0;
      rd_data_q <= 1'b0;
      rd_stat_q <= 1'b0;
    end else begin
      rd_data_q <= rd_data_dec;
      rd_stat_q <= rd_stat_dec;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A new flag event outranks a clear landing on the same clock.
      if (ovr_set)           ovr <= 1'b1;
      else if (rd_stat_edge) ovr <= 1'b0;
      if (ferr_set)          ferr <= 1'b1;
      else if (rd_stat_edge) ferr <= 1'b0;
    end
  end

  assign head     = empty ? 8'h00 : mem[rd_ptr];
  assign data_out = rd_data_dec ? head : {5'b0, ferr, ovr, ~empty};
  assign data_oe  = rd_data_dec || rd_stat_dec;
  assign Data     = data_oe ? data_out : 8'hzz;

endmodule
